// File: rtl/mgmt_gpio_pkg.sv
// Shared constants for the management GPIO controller.
//   - register-port geometry (address / data widths)
//   - register addresses of the housekeeping register map
//   - default line counts, output-enable reset value, warm-up terminal count
package mgmt_gpio_pkg;

    localparam int ADDR_W = 3;
    localparam int DATA_W = 32;

    // Default geometry: NPADS matches `MPRJ_IO_PADS_1, NOEB lines have
    // output-enable control.
    localparam int DEF_NPADS = 19;
    localparam int DEF_NOEB  = 3;

    localparam logic [ADDR_W-1:0] ADDR_OUT     = 3'd0;
    localparam logic [ADDR_W-1:0] ADDR_OUT_SET = 3'd1;
    localparam logic [ADDR_W-1:0] ADDR_OUT_CLR = 3'd2;
    localparam logic [ADDR_W-1:0] ADDR_OEB     = 3'd3;
    localparam logic [ADDR_W-1:0] ADDR_IN      = 3'd4;
    localparam logic [ADDR_W-1:0] ADDR_EDGE    = 3'd5;
    localparam logic [ADDR_W-1:0] ADDR_MASK    = 3'd6;
    localparam logic [ADDR_W-1:0] ADDR_RSVD    = 3'd7;

    // Every line comes out of reset as an input (oeb is active-low).
    localparam logic [DEF_NOEB-1:0] OEB_RST = '1;

    // Edge detection is enabled once the warm-up counter reaches this value.
    localparam logic [1:0] WARM_TC = 2'd3;

endpackage

// File: rtl/mgmt_gpio_if.sv
// Single-cycle housekeeping register port of the management GPIO controller.
//   wr_en / wr_addr / wr_data : one register write per asserted cycle
//   rd_en / rd_addr           : read request
//   rd_data                   : registered read data from the controller
// master = housekeeping side, slave = GPIO controller side.
interface mgmt_gpio_if;
    import mgmt_gpio_pkg::*;

    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic              rd_en;
    logic [ADDR_W-1:0] rd_addr;
    logic [DATA_W-1:0] rd_data;

    modport master (
        output wr_en, wr_addr, wr_data, rd_en, rd_addr,
        input  rd_data
    );

    modport slave (
        input  wr_en, wr_addr, wr_data, rd_en, rd_addr,
        output rd_data
    );

endinterface

// File: rtl/mgmt_gpio_sync.sv
// Parameterised-width two-flop synchroniser. This is the only logic that
// samples the asynchronous pad inputs.
//   clk        : destination clock
//   rstn       : synchronous active-low reset, clears both stages
//   data_async : asynchronous input vector
//   data_sync  : synchronised output (second stage)
module mgmt_gpio_sync #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic [WIDTH-1:0] data_async,
    output logic [WIDTH-1:0] data_sync
);

    logic [WIDTH-1:0] meta_reg;
    logic [WIDTH-1:0] sync_reg;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            meta_reg <= '0;
            sync_reg <= '0;
        end else begin
            meta_reg <= data_async;
            sync_reg <= meta_reg;
        end
    end

    assign data_sync = sync_reg;

endmodule

// File: rtl/mgmt_gpio_ctrl.sv
// Management-side GPIO controller feeding the management I/O buffer stage.
// Owns the registered output and output-enable vectors, synchronises the
// buffered pad inputs, latches rising edges into a sticky W1C status
// register and raises a masked level interrupt.
//   wb_clk_i      : clock
//   wb_rstn_i     : synchronous active-low reset
//   bus           : housekeeping register port (slave side)
//   mgmt_gpio_in  : buffered pad inputs (asynchronous)
//   mgmt_gpio_out : registered output values
//   mgmt_gpio_oeb : registered output enables, active-low (1 = input)
//   irq           : registered level interrupt, |(EDGE & MASK)
module mgmt_gpio_ctrl
    import mgmt_gpio_pkg::*;
#(
    parameter int NPADS = DEF_NPADS,
    parameter int NOEB  = DEF_NOEB
) (
    input  logic             wb_clk_i,
    input  logic             wb_rstn_i,
    mgmt_gpio_if.slave       bus,
    input  logic [NPADS-1:0] mgmt_gpio_in,
    output logic [NPADS-1:0] mgmt_gpio_out,
    output logic [NOEB-1:0]  mgmt_gpio_oeb,
    output logic             irq
);

    logic [NPADS-1:0]  out_reg;
    logic [NPADS-1:0]  out_next;
    logic [NOEB-1:0]   oeb_reg;
    logic [NPADS-1:0]  edge_reg;
    logic [NPADS-1:0]  edge_next;
    logic [NPADS-1:0]  mask_reg;
    logic [NPADS-1:0]  hist_reg;
    logic [1:0]        warm_reg;
    logic              irq_reg;
    logic [DATA_W-1:0] rd_data_reg;
    logic [DATA_W-1:0] rd_data_next;

    logic [NPADS-1:0]  in_sync;
    logic [NPADS-1:0]  rise;
    logic [NPADS-1:0]  wr_bits;
    logic              warm_done;
    logic              wr_out;
    logic              wr_set;
    logic              wr_clr;
    logic              wr_oeb;
    logic              wr_edge;
    logic              wr_mask;

    mgmt_gpio_sync #(
        .WIDTH (NPADS)
    ) u_sync (
        .clk        (wb_clk_i),
        .rstn       (wb_rstn_i),
        .data_async (mgmt_gpio_in),
        .data_sync  (in_sync)
    );

    // Write decode; reserved address 7 decodes to nothing.
    assign wr_bits = bus.wr_data[NPADS-1:0];
    assign wr_out  = bus.wr_en && (bus.wr_addr == ADDR_OUT);
    assign wr_set  = bus.wr_en && (bus.wr_addr == ADDR_OUT_SET);
    assign wr_clr  = bus.wr_en && (bus.wr_addr == ADDR_OUT_CLR);
    assign wr_oeb  = bus.wr_en && (bus.wr_addr == ADDR_OEB);
    assign wr_edge = bus.wr_en && (bus.wr_addr == ADDR_EDGE);
    assign wr_mask = bus.wr_en && (bus.wr_addr == ADDR_MASK);

    // Data bits above the pad count carry no meaning.
    generate
        if (NPADS < DATA_W) begin : g_unused_hi
            logic unused_wr_hi;
            assign unused_wr_hi = ^bus.wr_data[DATA_W-1:NPADS];
        end
    endgenerate

    always_comb begin
        out_next = out_reg;
        if (wr_out) begin
            out_next = wr_bits;
        end else if (wr_set) begin
            out_next = out_reg | wr_bits;
        end else if (wr_clr) begin
            out_next = out_reg & ~wr_bits;
        end
    end

    // Suppress detection until the synchroniser and history flop hold real
    // pin samples, so pins already high at reset release are not reported.
    assign warm_done = (warm_reg == WARM_TC);

    genvar gi;
    generate
        for (gi = 0; gi < NPADS; gi++) begin : g_edge
            assign rise[gi] = warm_done && in_sync[gi] && !hist_reg[gi];
            // A new edge beats a simultaneous write-1-to-clear.
            assign edge_next[gi] = rise[gi] ||
                                   (edge_reg[gi] && !(wr_edge && wr_bits[gi]));
        end
    endgenerate

    // Read mux works on current register values, so a read in the same
    // cycle as a write returns the pre-write contents.
    always_comb begin
        rd_data_next = '0;
        case (bus.rd_addr)
            ADDR_OUT:  rd_data_next = DATA_W'(out_reg);
            ADDR_OEB:  rd_data_next = DATA_W'(oeb_reg);
            ADDR_IN:   rd_data_next = DATA_W'(in_sync);
            ADDR_EDGE: rd_data_next = DATA_W'(edge_reg);
            ADDR_MASK: rd_data_next = DATA_W'(mask_reg);
            default:   rd_data_next = '0;
        endcase
    end

    always_ff @(posedge wb_clk_i) begin
        if (!wb_rstn_i) begin
            out_reg     <= '0;
            oeb_reg     <= {NOEB{OEB_RST[0]}};
            edge_reg    <= '0;
            mask_reg    <= '0;
            hist_reg    <= '0;
            warm_reg    <= '0;
            irq_reg     <= 1'b0;
            rd_data_reg <= '0;
        end else begin
            out_reg  <= out_next;
            edge_reg <= edge_next;
            hist_reg <= in_sync;
            irq_reg  <= |(edge_reg & mask_reg);
            if (wr_oeb) begin
                oeb_reg <= bus.wr_data[NOEB-1:0];
            end
            if (wr_mask) begin
                mask_reg <= wr_bits;
            end
            if (!warm_done) begin
                warm_reg <= warm_reg + 2'd1;
            end
            if (bus.rd_en) begin
                rd_data_reg <= rd_data_next;
            end
        end
    end

    assign mgmt_gpio_out = out_reg;
    assign mgmt_gpio_oeb = oeb_reg;
    assign irq           = irq_reg;
    assign bus.rd_data   = rd_data_reg;

endmodule

// File: tb/tb_mgmt_gpio_ctrl.sv
// Self-checking bench for mgmt_gpio_ctrl: directed register-port and pin
// stimulus, a per-cycle compare against a register-map model, and literal
// expectations at the key points of the sequence.
module tb_mgmt_gpio_ctrl;
    import mgmt_gpio_pkg::*;

    localparam int NP = 19;
    localparam int NO = 3;

    logic          clk;
    logic          rstn;
    logic [NP-1:0] pins;
    logic [NP-1:0] gpio_out;
    logic [NO-1:0] gpio_oeb;
    logic          irq;

    int total = 0;
    int bad   = 0;

    mgmt_gpio_if bus ();

    mgmt_gpio_ctrl #(
        .NPADS (NP),
        .NOEB  (NO)
    ) dut (
        .wb_clk_i      (clk),
        .wb_rstn_i     (rstn),
        .bus           (bus),
        .mgmt_gpio_in  (pins),
        .mgmt_gpio_out (gpio_out),
        .mgmt_gpio_oeb (gpio_oeb),
        .irq           (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Register map state plus the pin values seen at the last three edges
    // (seen[0] = most recent). IN shows the pin value from two edges back;
    // a rising edge is a 0 -> 1 between the pin values seen two and three
    // edges back, counted only once four edges have passed since reset.
    logic [NP-1:0] m_out, m_edge, m_mask;
    logic [NO-1:0] m_oeb;
    logic          m_irq;
    logic [31:0]   m_rd;
    logic [NP-1:0] seen [0:2];
    int            since;
    logic          model_ok = 1'b0;

    always @(posedge clk) begin : model
        logic [NP-1:0] rise;
        logic [NP-1:0] wbits;
        logic [NP-1:0] clr;
        if (!rstn) begin
            m_out    <= '0;
            m_oeb    <= 3'b111;
            m_edge   <= '0;
            m_mask   <= '0;
            m_irq    <= 1'b0;
            m_rd     <= '0;
            seen[0]  <= '0;
            seen[1]  <= '0;
            seen[2]  <= '0;
            since    <= 0;
            model_ok <= 1'b1;
        end else begin
            wbits = bus.wr_data[NP-1:0];
            rise  = (since >= 3) ? (seen[1] & ~seen[2]) : '0;
            clr   = (bus.wr_en && bus.wr_addr == 3'd5) ? wbits : '0;
            m_edge <= rise | (m_edge & ~clr);
            m_irq  <= |(m_edge & m_mask);
            if (bus.wr_en) begin
                case (bus.wr_addr)
                    3'd0: m_out  <= wbits;
                    3'd1: m_out  <= m_out | wbits;
                    3'd2: m_out  <= m_out & ~wbits;
                    3'd3: m_oeb  <= bus.wr_data[NO-1:0];
                    3'd6: m_mask <= wbits;
                    default: ;
                endcase
            end
            if (bus.rd_en) begin
                case (bus.rd_addr)
                    3'd0:    m_rd <= 32'(m_out);
                    3'd3:    m_rd <= 32'(m_oeb);
                    3'd4:    m_rd <= 32'(seen[1]);
                    3'd5:    m_rd <= 32'(m_edge);
                    3'd6:    m_rd <= 32'(m_mask);
                    default: m_rd <= '0;
                endcase
            end
            seen[0] <= pins;
            seen[1] <= seen[0];
            seen[2] <= seen[1];
            if (since < 3) since <= since + 1;
        end
    end

    // Per-cycle compare of every DUT output against the model.
    always @(negedge clk) begin
        if (model_ok) begin
            check("cyc_out", 32'(gpio_out), 32'(m_out));
            check("cyc_oeb", 32'(gpio_oeb), 32'(m_oeb));
            check("cyc_irq", 32'(irq), 32'(m_irq));
            check("cyc_rd", bus.rd_data, m_rd);
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_write(input logic [2:0] a, input logic [31:0] d);
        bus.wr_en   = 1'b1;
        bus.wr_addr = a;
        bus.wr_data = d;
        @(negedge clk);
        bus.wr_en   = 1'b0;
    endtask

    task automatic do_read(input string nm, input logic [2:0] a, input logic [31:0] exp);
        bus.rd_en   = 1'b1;
        bus.rd_addr = a;
        @(negedge clk);
        bus.rd_en   = 1'b0;
        check(nm, bus.rd_data, exp);
        $display("read  addr=%0d data=%h", a, bus.rd_data);
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_out"}, 32'(gpio_out), 32'h0);
        check({tag, "_oeb"}, 32'(gpio_oeb), 32'h7);
        check({tag, "_irq"}, 32'(irq), 32'h0);
        check({tag, "_rd"}, bus.rd_data, 32'h0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rstn        = 1'b0;
        bus.wr_en   = 1'b0;
        bus.wr_addr = '0;
        bus.wr_data = '0;
        bus.rd_en   = 1'b0;
        bus.rd_addr = '0;
        pins        = 19'h00020;     // bit 5 held high through reset release
        cyc(3);
        check_reset_state("rst");
        rstn = 1'b1;

        // IN[5] visible two edges after release; no edge reported.
        cyc(2);
        do_read("in_warm", ADDR_IN, 32'h00000020);
        cyc(4);
        do_read("edge_warm", ADDR_EDGE, 32'h0);

        // OUT / SET / CLR
        do_write(ADDR_OUT, 32'h0000000F);
        $display("write addr=0 data=0000000f");
        do_write(ADDR_OUT_SET, 32'h00030000);
        $display("write addr=1 data=00030000");
        do_write(ADDR_OUT_CLR, 32'h00000003);
        $display("write addr=2 data=00000003");
        check("out_setclr", 32'(gpio_out), 32'h0003000C);
        do_read("rd_out", ADDR_OUT, 32'h0003000C);
        do_read("rd_set", ADDR_OUT_SET, 32'h0);
        do_read("rd_clr", ADDR_OUT_CLR, 32'h0);

        // OEB and reserved address
        do_write(ADDR_OEB, 32'hFFFFFFFA);
        check("oeb_wr", 32'(gpio_oeb), 32'h2);
        do_read("rd_oeb", ADDR_OEB, 32'h2);
        do_write(ADDR_RSVD, 32'hFFFFFFFF);
        check("rsvd_out", 32'(gpio_out), 32'h0003000C);
        do_read("rd_rsvd", ADDR_RSVD, 32'h0);

        // Rising edge on bit 2 with MASK = 0x4
        do_write(ADDR_MASK, 32'h4);
        pins = pins | 19'h00004;
        cyc(3);
        check("irq_pre", 32'(irq), 32'h0);
        do_read("edge_bit2", ADDR_EDGE, 32'h4);
        check("irq_rise", 32'(irq), 32'h1);
        do_write(ADDR_EDGE, 32'h4);
        check("irq_w1c_hold", 32'(irq), 32'h1);
        cyc(1);
        check("irq_w1c_drop", 32'(irq), 32'h0);
        do_read("edge_clr", ADDR_EDGE, 32'h0);

        // New edge on bit 7 coinciding with W1C of bit 7: set wins.
        pins = pins | 19'h00080;
        cyc(2);
        do_write(ADDR_EDGE, 32'h80);
        do_read("edge_collide", ADDR_EDGE, 32'h80);
        check("irq_unmasked", 32'(irq), 32'h0);

        // Unmask bit 7 -> irq rises two edges after the MASK write.
        do_write(ADDR_MASK, 32'h84);
        cyc(1);
        check("irq_mask7", 32'(irq), 32'h1);

        // Simultaneous write and read: read returns pre-write value.
        bus.wr_en   = 1'b1;
        bus.wr_addr = ADDR_OUT;
        bus.wr_data = 32'hFFF7FFFF;
        bus.rd_en   = 1'b1;
        bus.rd_addr = ADDR_OUT;
        @(negedge clk);
        bus.wr_en = 1'b0;
        bus.rd_en = 1'b0;
        check("rw_pre", bus.rd_data, 32'h0003000C);
        check("rw_out", 32'(gpio_out), 32'h0007FFFF);
        $display("rw    addr=0 wdata=fff7ffff rdata=%h", bus.rd_data);
        check("irq_before_rst", 32'(irq), 32'h1);

        // Reset mid-operation with a write pending in the same cycle.
        rstn        = 1'b0;
        bus.wr_en   = 1'b1;
        bus.wr_addr = ADDR_OEB;
        bus.wr_data = 32'h0;
        @(negedge clk);
        bus.wr_en = 1'b0;
        check_reset_state("midrst");
        rstn = 1'b1;

        // Pins 2, 5, 7 high across release: no edges, status cleared.
        cyc(5);
        do_read("edge_after_rst", ADDR_EDGE, 32'h0);
        do_read("mask_after_rst", ADDR_MASK, 32'h0);
        do_read("in_after_rst", ADDR_IN, 32'h000000A4);
        do_read("oeb_after_rst", ADDR_OEB, 32'h7);
        check("irq_after_rst", 32'(irq), 32'h0);

        cyc(2);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
